stage_id_decode: RTL and testbench



---
 rtl/stage_id_decode.sv | 235 +++++++++++++++++++++++
 tb/tb_stage_id_decode.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/stage_id_decode.sv
// -----------------------------------------------------------------------------
// stage_id_decode
//   Instruction-decode stage of the five-stage pipeline. Decodes a MIPS32
//   subset (ADD/SUB/AND/OR/SLT, ADDI, LW, SW, BEQ, J) and owns the 32x32
//   register file, which has a write-before-read bypass from WB. It detects
//   load-use hazards, raising Stall to freeze IF, and registers a bubble on a
//   stall or on a flush from MEM. All EndStageID_* outputs are registered.
//
// Optional feature: define ID_STALL_CNT_EN to get a saturating 16-bit count
//   of stalled cycles on StallCount; otherwise StallCount is constant 0.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   FromIF_NewPC/Inst/InstNum  fetched PC+1, instruction word, sequence tag
//   FromEX_MemRead/Rt       LW currently in EX and its destination
//   FromMEM_Flush           kill the instruction in this stage (bubble)
//   FromWB_RegWrite/Rd/Data register-file write port
//   Stall                   combinational load-use stall to IF
//   EndStageID_*            registered operands, immediate and control to EX
//   StallCount              stalled-cycle counter (optional feature)
// -----------------------------------------------------------------------------
module stage_id_decode #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       FromIF_NewPC,
    input  logic [31:0]       FromIF_Inst,
    input  logic [3:0]        FromIF_InstNum,
    input  logic              FromEX_MemRead,
    input  logic [4:0]        FromEX_Rt,
    input  logic              FromMEM_Flush,
    input  logic              FromWB_RegWrite,
    input  logic [4:0]        FromWB_Rd,
    input  logic [DATA_W-1:0] FromWB_Data,
    output logic              Stall,
    output logic [31:0]       EndStageID_NewPC,
    output logic [DATA_W-1:0] EndStageID_RsData,
    output logic [DATA_W-1:0] EndStageID_RtData,
    output logic [DATA_W-1:0] EndStageID_Imm,
    output logic [4:0]        EndStageID_Rs,
    output logic [4:0]        EndStageID_Rt,
    output logic [4:0]        EndStageID_Rd,
    output logic              EndStageID_RegWrite,
    output logic              EndStageID_MemRead,
    output logic              EndStageID_MemWrite,
    output logic              EndStageID_ALUSrcImm,
    output logic [2:0]        EndStageID_ALUOp,
    output logic [3:0]        EndStageID_InstNum,
    output logic [3:0]        EndStageID_InstType,
    output logic [15:0]       StallCount
);

    localparam logic [3:0] TYPE_NONE = 4'd0, TYPE_RTYPE = 4'd1, TYPE_ADDI = 4'd2,
                           TYPE_LW   = 4'd3, TYPE_SW    = 4'd4, TYPE_BEQ  = 4'd5,
                           TYPE_J    = 4'd6;
    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                           ALU_OR  = 3'd3, ALU_SLT = 3'd4;

    typedef struct packed {
        logic [31:0]       new_pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              alu_src_imm;
        logic [2:0]        alu_op;
        logic [3:0]        inst_num;
        logic [3:0]        inst_type;
    } id_out_t;

    logic [5:0]        opcode_s, funct_s;
    logic [4:0]        rs_f_s, rt_f_s, rd_f_s;
    logic [DATA_W-1:0] imm_sext_s, imm_j_s;
    logic [DATA_W-1:0] rs_rdata_s, rt_rdata_s;
    logic [3:0]        dec_type_s;
    logic [2:0]        dec_aluop_s;
    logic              uses_rs_s, uses_rt_s, load_use_s;
    id_out_t           dec_s, out_d, out_q;
    logic [DATA_W-1:0] regs_q [NREGS];

    assign opcode_s   = FromIF_Inst[31:26];
    assign rs_f_s     = FromIF_Inst[25:21];
    assign rt_f_s     = FromIF_Inst[20:16];
    assign rd_f_s     = FromIF_Inst[15:11];
    assign funct_s    = FromIF_Inst[5:0];
    assign imm_sext_s = {{(DATA_W-16){FromIF_Inst[15]}}, FromIF_Inst[15:0]};
    assign imm_j_s    = {{(DATA_W-26){1'b0}}, FromIF_Inst[25:0]};

    // Register 0 always reads zero and is never bypassed; otherwise a
    // same-cycle WB write to the register being read wins over the array.
    assign rs_rdata_s = (rs_f_s == 5'd0) ? '0 :
                        (FromWB_RegWrite && (FromWB_Rd == rs_f_s)) ? FromWB_Data : regs_q[rs_f_s];
    assign rt_rdata_s = (rt_f_s == 5'd0) ? '0 :
                        (FromWB_RegWrite && (FromWB_Rd == rt_f_s)) ? FromWB_Data : regs_q[rt_f_s];

    // Register file: synchronous clear, r0 writes dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (FromWB_RegWrite && (FromWB_Rd != 5'd0)) begin
            regs_q[FromWB_Rd] <= FromWB_Data;
        end
    end

    // Classify the instruction and pick its ALU operation.
    always_comb begin
        dec_type_s  = TYPE_NONE;
        dec_aluop_s = ALU_ADD;
        case (opcode_s)
            6'h00: begin
                case (funct_s)
                    6'h20:   begin dec_type_s = TYPE_RTYPE; dec_aluop_s = ALU_ADD; end
                    6'h22:   begin dec_type_s = TYPE_RTYPE; dec_aluop_s = ALU_SUB; end
                    6'h24:   begin dec_type_s = TYPE_RTYPE; dec_aluop_s = ALU_AND; end
                    6'h25:   begin dec_type_s = TYPE_RTYPE; dec_aluop_s = ALU_OR;  end
                    6'h2A:   begin dec_type_s = TYPE_RTYPE; dec_aluop_s = ALU_SLT; end
                    default: begin dec_type_s = TYPE_NONE;  dec_aluop_s = ALU_ADD; end
                endcase
            end
            6'h08:   dec_type_s = TYPE_ADDI;
            6'h23:   dec_type_s = TYPE_LW;
            6'h2B:   dec_type_s = TYPE_SW;
            6'h04:   begin dec_type_s = TYPE_BEQ; dec_aluop_s = ALU_SUB; end
            6'h02:   dec_type_s = TYPE_J;
            default: dec_type_s = TYPE_NONE;
        endcase
    end

    // Build the full decoded bundle; unsupported encodings stay all-zero control.
    always_comb begin
        dec_s           = '0;
        dec_s.new_pc    = FromIF_NewPC;
        dec_s.inst_num  = FromIF_InstNum;
        dec_s.inst_type = dec_type_s;
        dec_s.alu_op    = dec_aluop_s;
        if (uses_rs_s) begin
            dec_s.rs      = rs_f_s;
            dec_s.rt      = rt_f_s;
            dec_s.rs_data = rs_rdata_s;
            dec_s.rt_data = rt_rdata_s;
            dec_s.imm     = imm_sext_s;
        end else begin
            dec_s.rs = 5'd0;
        end
        case (dec_type_s)
            TYPE_RTYPE: begin dec_s.reg_write = 1'b1; dec_s.rd = rd_f_s; end
            TYPE_ADDI:  begin dec_s.reg_write = 1'b1; dec_s.alu_src_imm = 1'b1; dec_s.rd = rt_f_s; end
            TYPE_LW:    begin
                dec_s.reg_write   = 1'b1;
                dec_s.mem_read    = 1'b1;
                dec_s.alu_src_imm = 1'b1;
                dec_s.rd          = rt_f_s;
            end
            TYPE_SW:    begin dec_s.mem_write = 1'b1; dec_s.alu_src_imm = 1'b1; end
            TYPE_BEQ:   dec_s.rd = 5'd0;
            TYPE_J:     dec_s.imm = imm_j_s;
            default:    dec_s.inst_type = TYPE_NONE;
        endcase
    end

    assign uses_rs_s = (dec_type_s inside {TYPE_RTYPE, TYPE_ADDI, TYPE_LW, TYPE_SW, TYPE_BEQ});
    assign uses_rt_s = (dec_type_s inside {TYPE_RTYPE, TYPE_SW, TYPE_BEQ});

    assign load_use_s = FromEX_MemRead && (FromEX_Rt != 5'd0) &&
                        ((uses_rs_s && (FromEX_Rt == rs_f_s)) || (uses_rt_s && (FromEX_Rt == rt_f_s)));
    // A flush kills this instruction anyway, so it suppresses the stall.
    assign Stall = load_use_s && !FromMEM_Flush;

    // Flush or stall inserts a bubble (everything zero, InstType NONE).
    always_comb begin
        if (FromMEM_Flush || Stall) begin
            out_d = '0;
        end else begin
            out_d = dec_s;
        end
    end

    // Pipeline register toward EX.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign EndStageID_NewPC     = out_q.new_pc;
    assign EndStageID_RsData    = out_q.rs_data;
    assign EndStageID_RtData    = out_q.rt_data;
    assign EndStageID_Imm       = out_q.imm;
    assign EndStageID_Rs        = out_q.rs;
    assign EndStageID_Rt        = out_q.rt;
    assign EndStageID_Rd        = out_q.rd;
    assign EndStageID_RegWrite  = out_q.reg_write;
    assign EndStageID_MemRead   = out_q.mem_read;
    assign EndStageID_MemWrite  = out_q.mem_write;
    assign EndStageID_ALUSrcImm = out_q.alu_src_imm;
    assign EndStageID_ALUOp     = out_q.alu_op;
    assign EndStageID_InstNum   = out_q.inst_num;
    assign EndStageID_InstType  = out_q.inst_type;

`ifdef ID_STALL_CNT_EN
    logic [15:0] stall_cnt_d, stall_cnt_q;

    // Saturating count of stalled cycles.
    always_comb begin
        if (Stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
`else
    assign StallCount = 16'h0000;
`endif

endmodule

// File: tb/tb_stage_id_decode.sv
module tb_stage_id_decode;

    logic        clock;
    logic        reset;
    logic [31:0] FromIF_NewPC, FromIF_Inst;
    logic [3:0]  FromIF_InstNum;
    logic        FromEX_MemRead;
    logic [4:0]  FromEX_Rt;
    logic        FromMEM_Flush;
    logic        FromWB_RegWrite;
    logic [4:0]  FromWB_Rd;
    logic [31:0] FromWB_Data;
    logic        Stall;
    logic [31:0] EndStageID_NewPC, EndStageID_RsData, EndStageID_RtData, EndStageID_Imm;
    logic [4:0]  EndStageID_Rs, EndStageID_Rt, EndStageID_Rd;
    logic        EndStageID_RegWrite, EndStageID_MemRead, EndStageID_MemWrite, EndStageID_ALUSrcImm;
    logic [2:0]  EndStageID_ALUOp;
    logic [3:0]  EndStageID_InstNum, EndStageID_InstType;
    logic [15:0] StallCount;

    stage_id_decode dut (
        .clock(clock), .reset(reset),
        .FromIF_NewPC(FromIF_NewPC), .FromIF_Inst(FromIF_Inst), .FromIF_InstNum(FromIF_InstNum),
        .FromEX_MemRead(FromEX_MemRead), .FromEX_Rt(FromEX_Rt), .FromMEM_Flush(FromMEM_Flush),
        .FromWB_RegWrite(FromWB_RegWrite), .FromWB_Rd(FromWB_Rd), .FromWB_Data(FromWB_Data),
        .Stall(Stall),
        .EndStageID_NewPC(EndStageID_NewPC), .EndStageID_RsData(EndStageID_RsData),
        .EndStageID_RtData(EndStageID_RtData), .EndStageID_Imm(EndStageID_Imm),
        .EndStageID_Rs(EndStageID_Rs), .EndStageID_Rt(EndStageID_Rt), .EndStageID_Rd(EndStageID_Rd),
        .EndStageID_RegWrite(EndStageID_RegWrite), .EndStageID_MemRead(EndStageID_MemRead),
        .EndStageID_MemWrite(EndStageID_MemWrite), .EndStageID_ALUSrcImm(EndStageID_ALUSrcImm),
        .EndStageID_ALUOp(EndStageID_ALUOp), .EndStageID_InstNum(EndStageID_InstNum),
        .EndStageID_InstType(EndStageID_InstType), .StallCount(StallCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        bubble;
        logic [31:0] newpc;
        logic [3:0]  instnum;
        logic [3:0]  itype;
        logic [2:0]  aluop;
        logic [4:0]  rs, rt, rd;
        logic [3:0]  ctl;
        logic [31:0] imm, rsdata, rtdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] model_rf [32];
    logic [31:0] pc;
    int          n_checks;
    int          n_fail;
    int          exp_stall_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (FromWB_RegWrite && (FromWB_Rd == idx)) return FromWB_Data;
        return model_rf[idx];
    endfunction

    // One instruction presented for one clock; ctl = {RegWrite,MemRead,MemWrite,ALUSrcImm}.
    task automatic step(input string tag, input logic [31:0] inst, input logic [3:0] itype,
                        input logic [2:0] aluop, input logic [4:0] rd, input logic [3:0] ctl,
                        input logic [31:0] imm, input logic exp_stall);
        exp_t e;
        exp_t got;
        @(negedge clock);
        pc             = pc + 32'd1;
        FromIF_Inst    = inst;
        FromIF_NewPC   = pc;
        FromIF_InstNum = pc[3:0];
        #1;
        check_val({tag, "/stall"}, 32'(Stall), 32'(exp_stall));
        e.bubble  = reset | FromMEM_Flush | exp_stall;
        e.newpc   = pc;
        e.instnum = pc[3:0];
        e.itype   = itype;
        e.aluop   = aluop;
        e.rs      = inst[25:21];
        e.rt      = inst[20:16];
        e.rd      = rd;
        e.ctl     = ctl;
        e.imm     = imm;
        e.rsdata  = model_read(inst[25:21]);
        e.rtdata  = model_read(inst[20:16]);
        sb_q.push_back(e);
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
            exp_stall_cnt = 0;
        end else begin
            if (FromWB_RegWrite && (FromWB_Rd != 5'd0)) model_rf[FromWB_Rd] = FromWB_Data;
`ifdef ID_STALL_CNT_EN
            if (exp_stall && (exp_stall_cnt < 65535)) exp_stall_cnt++;
`endif
        end
        #1;
        check_val({tag, "/stallcnt"}, 32'(StallCount), 32'(exp_stall_cnt));
        if (sb_q.size() == 0) begin
            check_val({tag, "/sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            if (got.bubble) begin
                check_val({tag, "/b_type"}, 32'(EndStageID_InstType), 32'd0);
                check_val({tag, "/b_ctl"}, 32'({EndStageID_RegWrite, EndStageID_MemRead,
                          EndStageID_MemWrite, EndStageID_ALUSrcImm}), 32'd0);
                check_val({tag, "/b_aluop"}, 32'(EndStageID_ALUOp), 32'd0);
                check_val({tag, "/b_pc"}, EndStageID_NewPC, 32'd0);
                check_val({tag, "/b_num"}, 32'(EndStageID_InstNum), 32'd0);
                check_val({tag, "/b_regs"}, 32'({EndStageID_Rs, EndStageID_Rt, EndStageID_Rd}), 32'd0);
                check_val({tag, "/b_imm"}, EndStageID_Imm, 32'd0);
                check_val({tag, "/b_rsdata"}, EndStageID_RsData, 32'd0);
                check_val({tag, "/b_rtdata"}, EndStageID_RtData, 32'd0);
            end else begin
                check_val({tag, "/type"}, 32'(EndStageID_InstType), 32'(got.itype));
                check_val({tag, "/ctl"}, 32'({EndStageID_RegWrite, EndStageID_MemRead,
                          EndStageID_MemWrite, EndStageID_ALUSrcImm}), 32'(got.ctl));
                check_val({tag, "/aluop"}, 32'(EndStageID_ALUOp), 32'(got.aluop));
                check_val({tag, "/pc"}, EndStageID_NewPC, got.newpc);
                check_val({tag, "/num"}, 32'(EndStageID_InstNum), 32'(got.instnum));
                if (got.itype inside {4'd1, 4'd2, 4'd3})
                    check_val({tag, "/rd"}, 32'(EndStageID_Rd), 32'(got.rd));
                if (got.itype != 4'd0)
                    check_val({tag, "/imm"}, EndStageID_Imm, got.imm);
                if (got.itype inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}) begin
                    check_val({tag, "/rs"}, 32'(EndStageID_Rs), 32'(got.rs));
                    check_val({tag, "/rt"}, 32'(EndStageID_Rt), 32'(got.rt));
                    check_val({tag, "/rsdata"}, EndStageID_RsData, got.rsdata);
                    check_val({tag, "/rtdata"}, EndStageID_RtData, got.rtdata);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; exp_stall_cnt = 0; pc = 32'h0;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
        reset = 1'b1;
        FromIF_NewPC = 32'h0; FromIF_Inst = 32'h0; FromIF_InstNum = 4'h0;
        FromEX_MemRead = 1'b0; FromEX_Rt = 5'd0; FromMEM_Flush = 1'b0;
        FromWB_RegWrite = 1'b0; FromWB_Rd = 5'd0; FromWB_Data = 32'h0;

        step("reset", 32'h0000_0000, 4'd0, 3'd0, 5'd0, 4'b0000, 32'h0, 1'b0);
        reset = 1'b0;

        FromWB_RegWrite = 1'b1; FromWB_Rd = 5'd5; FromWB_Data = 32'h0000_1234;
        step("add_bypass", 32'h00A0_1820, 4'd1, 3'd0, 5'd3, 4'b1000, 32'h0000_1820, 1'b0);
        FromWB_Rd = 5'd3; FromWB_Data = 32'hA5A5_0003;
        step("and", 32'h00A3_3024, 4'd1, 3'd2, 5'd6, 4'b1000, 32'h0000_3024, 1'b0);
        FromWB_Rd = 5'd0; FromWB_Data = 32'hDEAD_BEEF;
        step("addi_r0wr", 32'h2007_FFFF, 4'd2, 3'd0, 5'd7, 4'b1001, 32'hFFFF_FFFF, 1'b0);
        FromWB_RegWrite = 1'b0;
        step("read_r0", 32'h00A0_1820, 4'd1, 3'd0, 5'd3, 4'b1000, 32'h0000_1820, 1'b0);

        FromEX_MemRead = 1'b1; FromEX_Rt = 5'd2;
        step("lu_stall", 32'h0043_2022, 4'd1, 3'd1, 5'd4, 4'b1000, 32'h0000_2022, 1'b1);
        FromEX_MemRead = 1'b0;
        step("lu_release", 32'h0043_2022, 4'd1, 3'd1, 5'd4, 4'b1000, 32'h0000_2022, 1'b0);

        FromMEM_Flush = 1'b1; FromEX_MemRead = 1'b1; FromEX_Rt = 5'd2;
        step("flush_wins", 32'h1022_0003, 4'd5, 3'd1, 5'd0, 4'b0000, 32'h0000_0003, 1'b0);
        FromMEM_Flush = 1'b0; FromEX_Rt = 5'd0;
        step("ex_rt0", 32'h00A0_1820, 4'd1, 3'd0, 5'd3, 4'b1000, 32'h0000_1820, 1'b0);
        FromEX_Rt = 5'd7;
        step("addi_nohaz", 32'h2007_FFFF, 4'd2, 3'd0, 5'd7, 4'b1001, 32'hFFFF_FFFF, 1'b0);
        FromEX_Rt = 5'd5;
        step("sw_rt_stall", 32'hAC65_0008, 4'd4, 3'd0, 5'd0, 4'b0011, 32'h0000_0008, 1'b1);
        FromEX_MemRead = 1'b0;
        step("sw", 32'hAC65_0008, 4'd4, 3'd0, 5'd0, 4'b0011, 32'h0000_0008, 1'b0);
        FromEX_MemRead = 1'b1; FromEX_Rt = 5'd1;
        step("beq_rs_stall", 32'h1022_0003, 4'd5, 3'd1, 5'd0, 4'b0000, 32'h0000_0003, 1'b1);
        FromEX_MemRead = 1'b0;
        step("beq", 32'h1022_0003, 4'd5, 3'd1, 5'd0, 4'b0000, 32'h0000_0003, 1'b0);
        FromEX_MemRead = 1'b1; FromEX_Rt = 5'd18;
        step("j_nohaz", 32'h0812_3456, 4'd6, 3'd0, 5'd0, 4'b0000, 32'h0012_3456, 1'b0);
        FromEX_MemRead = 1'b0;
        step("lw", 32'h8C22_0004, 4'd3, 3'd0, 5'd2, 4'b1101, 32'h0000_0004, 1'b0);
        step("slt", 32'h00A3_302A, 4'd1, 3'd4, 5'd6, 4'b1000, 32'h0000_302A, 1'b0);
        step("or", 32'h00A3_3025, 4'd1, 3'd3, 5'd6, 4'b1000, 32'h0000_3025, 1'b0);
        step("op3f", 32'hFC00_0000, 4'd0, 3'd0, 5'd0, 4'b0000, 32'h0, 1'b0);
        step("nop", 32'h0000_0000, 4'd0, 3'd0, 5'd0, 4'b0000, 32'h0, 1'b0);
        FromEX_MemRead = 1'b1; FromEX_Rt = 5'd5;
        step("bad_funct", 32'h00A3_3021, 4'd0, 3'd0, 5'd0, 4'b0000, 32'h0, 1'b0);

        reset = 1'b1; FromEX_Rt = 5'd2;
        step("reset_midstall", 32'h0043_2022, 4'd1, 3'd1, 5'd4, 4'b1000, 32'h0000_2022, 1'b1);
        reset = 1'b0; FromEX_MemRead = 1'b0;
        step("post_reset_rd", 32'h00A0_1820, 4'd1, 3'd0, 5'd3, 4'b1000, 32'h0000_1820, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
